// File: rtl/run_controller_if.sv
// Run-controller bus: core-side requests/indications and controller status outputs.
interface run_controller_if;
  logic        pause_req;
  logic        step_req;
  logic        halt_in;
  logic        core_reset;
  logic        core_en;
  logic        done;
  logic [31:0] cycle_count;
  logic [2:0]  state;

  modport master (
    output pause_req, step_req, halt_in,
    input  core_reset, core_en, done, cycle_count, state
  );

  modport slave (
    input  pause_req, step_req, halt_in,
    output core_reset, core_en, done, cycle_count, state
  );
endinterface

// File: rtl/run_controller.sv
// Core run controller: reset hold, run/pause, cycle budget and sticky done.
// Define RUN_CTRL_STEP_EN to compile in single-step support (STEP state).
module run_controller #(
  parameter int unsigned RESET_HOLD = 2,
  parameter int unsigned MAX_CYCLES = 100
) (
  input logic             clock,
  input logic             reset,
  run_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0]  HOLD_LAST = 8'(RESET_HOLD - 1);
  localparam logic [31:0] CYC_LAST  = 32'(MAX_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [31:0] count_q;
  logic        enabled;
  logic        finish;
  logic        step_edge;

`ifdef RUN_CTRL_STEP_EN
  logic step_q;

  always_ff @(posedge clock) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= bus.step_req;
  end

  assign step_edge = bus.step_req & ~step_q;
`else
  assign step_edge = 1'b0;
`endif

  assign enabled = (state_q == ST_RUN) || (state_q == ST_STEP);
  // Budget hit is detected on the last counted cycle so that cycle is still enabled.
  assign finish  = bus.halt_in || ((MAX_CYCLES != 0) && (count_q == CYC_LAST));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = ST_RUN;
        else                     hold_d  = hold_q + 8'd1;
      end
      ST_RUN: begin
        if (finish)             state_d = ST_DONE;
        else if (bus.pause_req) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (!bus.pause_req)  state_d = ST_RUN;
        else if (step_edge)  state_d = ST_STEP;
      end
      ST_STEP:  state_d = finish ? ST_DONE : ST_PAUSE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_HOLD;
      hold_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (enabled && (count_q != '1)) count_q <= count_q + 32'd1;
    end
  end

  assign bus.core_reset  = (state_q == ST_HOLD);
  assign bus.core_en     = enabled;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.cycle_count = count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed scenarios plus random traffic
// against a cycle-level behavioural model, on a default and an unlimited-budget instance.
module tb_run_controller;

`ifdef RUN_CTRL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  run_controller_if bus0();
  run_controller_if bus1();

  run_controller #(.RESET_HOLD(2), .MAX_CYCLES(100)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );
  run_controller #(.RESET_HOLD(1), .MAX_CYCLES(0)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  int checks   = 0;
  int failures = 0;

  // Model: phase 0=HOLD 1=RUN 2=PAUSE 3=STEP 4=DONE, hold as cycles remaining.
  int     m_state [2];
  int     m_left  [2];
  longint m_cnt   [2];
  bit     m_stepq;
  int     RH [2] = '{2, 1};
  longint MX [2] = '{100, 0};

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(bit rst, bit pause, bit step, bit halt);
    bit en, fin, stp_edge;
    int nxt;
    reset = rst;
    bus0.pause_req = pause; bus0.step_req = step; bus0.halt_in = halt;
    bus1.pause_req = pause; bus1.step_req = step; bus1.halt_in = halt;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_state[k] = 0;
        m_left[k]  = RH[k];
        m_cnt[k]   = 0;
      end else begin
        en       = (m_state[k] == 1) || (m_state[k] == 3);
        fin      = en && (halt || (MX[k] != 0 && m_cnt[k] + 1 == MX[k]));
        stp_edge = STEP_EN && step && !m_stepq;
        nxt      = m_state[k];
        case (m_state[k])
          0: begin m_left[k]--; if (m_left[k] == 0) nxt = 1; end
          1: if (fin) nxt = 4; else if (pause) nxt = 2;
          2: if (!pause) nxt = 1; else if (stp_edge) nxt = 3;
          3: nxt = fin ? 4 : 2;
          default: ;
        endcase
        if (en && m_cnt[k] < 64'hFFFF_FFFF) m_cnt[k]++;
        m_state[k] = nxt;
      end
    end
    m_stepq = rst ? 1'b0 : step;
    @(posedge clock);
    #1;
    chk("state0", bus0.state,       m_state[0]);
    chk("creset0", bus0.core_reset, m_state[0] == 0);
    chk("coreen0", bus0.core_en,    m_state[0] == 1 || m_state[0] == 3);
    chk("done0",  bus0.done,        m_state[0] == 4);
    chk("count0", bus0.cycle_count, m_cnt[0]);
    chk("state1", bus1.state,       m_state[1]);
    chk("creset1", bus1.core_reset, m_state[1] == 0);
    chk("coreen1", bus1.core_en,    m_state[1] == 1 || m_state[1] == 3);
    chk("done1",  bus1.done,        m_state[1] == 4);
    chk("count1", bus1.cycle_count, m_cnt[1]);
  endtask

  task automatic run_to(int target);
    int n = 0;
    while (m_cnt[0] != target && n < 400) begin
      tick(0, 0, 0, 0);
      n++;
    end
    chk("run_to_bound", bus0.cycle_count, target);
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
  endtask

  initial begin
    // Power-up reset and full default run to budget.
    do_reset();
    chk("rst_state", bus0.state, 0);
    chk("rst_creset", bus0.core_reset, 1);
    tick(0, 0, 0, 0);
    chk("hold_cycle2", bus0.core_reset, 1);
    for (int i = 0; i < 101; i++) tick(0, 0, 0, 0);
    chk("budget_done", bus0.done, 1);
    chk("budget_count", bus0.cycle_count, 100);
    chk("budget_state", bus0.state, 4);
    chk("unlimited_count", bus1.cycle_count, 101);
    tick(0, 1, 1, 1);
    chk("done_sticky", bus0.cycle_count, 100);

    // Halt at count 10.
    do_reset();
    run_to(10);
    tick(0, 0, 0, 1);
    chk("halt_done", bus0.done, 1);
    chk("halt_count", bus0.cycle_count, 11);
    chk("halt_coreen", bus0.core_en, 0);

    // Pause at count 20 held 5 cycles, then run out the budget.
    do_reset();
    run_to(20);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 0, 0);
      chk("pause_coreen", bus0.core_en, 0);
      chk("pause_count", bus0.cycle_count, 21);
    end
    for (int i = 0; i < 200 && m_state[0] != 4; i++) tick(0, 0, 0, 0);
    chk("pause_final", bus0.cycle_count, 100);

    // Single-stepping while paused.
    do_reset();
    run_to(20);
    tick(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 1, 0);
      chk("step_pulse", bus0.core_en, STEP_EN);
      tick(0, 1, 0, 0);
      chk("step_back", bus0.state, 2);
    end
    chk("step_count", bus0.cycle_count, STEP_EN ? 24 : 21);
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 0);
    chk("step_held", bus0.cycle_count, STEP_EN ? 25 : 21);

    // Reset in the middle of a run.
    do_reset();
    run_to(50);
    tick(1, 0, 0, 0);
    chk("midrst_count", bus0.cycle_count, 0);
    chk("midrst_creset", bus0.core_reset, 1);
    chk("midrst_state", bus0.state, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      tick(($urandom % 200) == 0, ($urandom % 4) == 0,
           ($urandom % 3) == 0, ($urandom % 150) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter RESET_HOLD, default 2: core reset cycles after `reset` deasserts; legal range 1..255.
REQ-002 Parameter MAX_CYCLES, default 100: enabled-cycle budget; 0 means unlimited.
REQ-003 Port clock  in  1  single clock; all state changes on rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port pause_req  in  1  level; high requests core freeze.
REQ-006 Port step_req  in  1  single-step request; rising edge acts.
REQ-007 Port halt_in  in  1  core halt indication; sampled only when core_en=1.
REQ-008 Port core_reset  out  1  reset to the processor core.
REQ-009 Port core_en  out  1  core clock-enable.
REQ-010 Port done  out  1  run finished; sticky.
REQ-011 Port cycle_count  out  32  number of enabled cycles so far.
REQ-012 Port state  out  3  HOLD=0, RUN=1, PAUSE=2, STEP=3, DONE=4.

Function
REQ-013 Outputs decode from registered state only: core_reset=(HOLD), core_en=(RUN|STEP), done=(DONE).
REQ-014 HOLD: internal 8-bit hold counter increments each cycle; at hold==RESET_HOLD-1 -> RUN next edge; core_reset high exactly RESET_HOLD cycles after reset release.
REQ-015 cycle_count increments by 1 on every edge where core_en=1; saturates at 0xFFFFFFFF.
REQ-016 RUN/STEP exit to DONE when halt_in=1 or (MAX_CYCLES!=0 and cycle_count==MAX_CYCLES-1); that final cycle is counted.
REQ-017 RUN: DONE condition has priority over pause_req; else pause_req=1 -> PAUSE; else stay RUN.
REQ-018 PAUSE: pause_req=0 -> RUN; step rising edge (with REQ-025) -> STEP; otherwise stay; halt_in ignored.
REQ-019 STEP: exactly one enabled cycle; next state DONE per REQ-016, else PAUSE regardless of pause_req.
REQ-020 Step edge detect: registered step_req_q; edge = step_req & ~step_req_q; held-high step_req yields one step only.
REQ-021 DONE: terminal until reset; cycle_count frozen; pause_req, step_req, halt_in ignored.
REQ-022 Simultaneous pause_req and step edge in RUN: pause taken, step edge discarded.

Reset
REQ-023 reset=1 at any edge, any state: next state HOLD, hold counter 0, cycle_count 0, step_req_q 0; outputs core_reset=1, core_en=0, done=0.
REQ-024 Reset held for N cycles keeps HOLD with hold counter at 0; hold counting starts on first edge with reset=0.

Configuration
REQ-025 Macro RUN_CTRL_STEP_EN defined: single-step logic (STEP state, step edge detector) compiled in.
REQ-026 Macro RUN_CTRL_STEP_EN undefined: step_req unused, STEP state unreachable, PAUSE leaves only via pause_req=0; all other behaviour identical.

Verification
REQ-027 Defaults, reset 2 cycles then low -> core_reset high 2 cycles, core_en high next 100 cycles, then done=1, cycle_count=100, state=4.
REQ-028 halt_in=1 in enabled cycle with cycle_count=10 -> next edge done=1, cycle_count=11, core_en=0.
REQ-029 pause_req high in RUN at cycle_count=20, held 5 cycles -> cycle_count=21 frozen, core_en=0 for 5 cycles, RUN resumes, done at 100.
REQ-030 With RUN_CTRL_STEP_EN, paused at count 21, three 1-cycle step_req pulses -> three single core_en pulses, count 24, state returns to 2.
REQ-031 reset=1 in RUN at cycle_count=50 -> next edge cycle_count=0, core_reset=1, core_en=0, done=0, state=0.
REQ-032 Without RUN_CTRL_STEP_EN, same as REQ-030 -> count stays 21, core_en stays 0.
